ddr3_bank_sched: RTL and testbench

Open-page DDR3 command scheduler that sits between the AXI-facing read/write request FIFOs and the DDR3 data-layer (DFI) command port. It tracks the open row of every bank, so row hits issue RD/WR directly, row conflicts issue PRE then ACT, and closed banks issue ACT. Read and write ports are arbitrated with row-hit priority and round-robin fairness. REFRESH requests from the DFI are serviced after a PRECHARGE-ALL when any bank is open. All DDR3 timing constraints are enforced downstream and exposed here only through `ddl_rdy_i`.

---
 rtl/ddr3_bank_sched.sv | 255 +++++++++++++++++++++++++
 tb/tb_ddr3_bank_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_bank_sched.sv
// Open-page DDR3 command scheduler. It tracks the open row of each bank and arbitrates the
// read and write ports. It sequences PRE/ACT/RD/WR commands and PRECHARGE-ALL/REFRESH to the DFI.
module ddr3_bank_sched #(
  parameter int         REQID         = 4,
  parameter int         DDR_ROW_BITS  = 13,
  parameter int         DDR_BANK_BITS = 3,
  parameter int         DDR_COL_BITS  = 10,
  parameter int         ADDRS         = DDR_ROW_BITS + DDR_BANK_BITS + DDR_COL_BITS - 3,
  parameter logic [2:0] CMD_ACTV      = 3'b011,
  parameter logic [2:0] CMD_READ      = 3'b101,
  parameter logic [2:0] CMD_WRIT      = 3'b100,
  parameter logic [2:0] CMD_PREC      = 3'b010,
  parameter logic [2:0] CMD_REFR      = 3'b001,
  parameter logic [2:0] CMD_NOOP      = 3'b111
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mem_wrreq_i,
  input  logic [REQID-1:0]         mem_wrtid_i,
  input  logic [ADDRS-1:0]         mem_wradr_i,
  output logic                     mem_wrack_o,
  input  logic                     mem_rdreq_i,
  input  logic [REQID-1:0]         mem_rdtid_i,
  input  logic [ADDRS-1:0]         mem_rdadr_i,
  output logic                     mem_rdack_o,
  output logic                     ddl_req_o,
  input  logic                     ddl_rdy_i,
  input  logic                     ddl_ref_i,
  output logic [2:0]               ddl_cmd_o,
  output logic [REQID-1:0]         ddl_tid_o,
  output logic [DDR_BANK_BITS-1:0] ddl_ba_o,
  output logic [DDR_ROW_BITS-1:0]  ddl_adr_o
);

  localparam int BANKS = 2 ** DDR_BANK_BITS;
  localparam int CFW   = DDR_COL_BITS - 3;
  localparam logic [DDR_ROW_BITS-1:0] ADR_A10 = {{(DDR_ROW_BITS-11){1'b0}}, 1'b1, 10'b0000000000};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREC = 3'd1,
    S_ACTV = 3'd2,
    S_RDWR = 3'd3,
    S_PREA = 3'd4,
    S_REFR = 3'd5,
    S_REFW = 3'd6
  } state_t;

  state_t                   r_state;
  logic                     r_req;
  logic [2:0]               r_cmd;
  logic [REQID-1:0]         r_tid;
  logic [DDR_BANK_BITS-1:0] r_ba;
  logic [DDR_ROW_BITS-1:0]  r_adr;
  logic                     r_wrack;
  logic                     r_rdack;
  logic                     r_prefer_rd;
  logic                     r_req_wr;
  logic [DDR_ROW_BITS-1:0]  r_req_row;
  logic [CFW-1:0]           r_req_col;
  logic [REQID-1:0]         r_req_tid;
  logic [BANKS-1:0]         r_open;
  logic [DDR_ROW_BITS-1:0]  r_row [BANKS];

  logic [DDR_ROW_BITS-1:0]  w_wr_row, w_rd_row, w_sel_row;
  logic [DDR_BANK_BITS-1:0] w_wr_ba, w_rd_ba, w_sel_ba;
  logic [CFW-1:0]           w_wr_col, w_rd_col, w_sel_col;
  logic [REQID-1:0]         w_sel_tid;
  logic                     w_wr_hit, w_rd_hit, w_sel_hit, w_sel_open, w_sel_wr;
  logic                     w_any_req, w_xfer, w_ack_cycle;

  function automatic logic [DDR_ROW_BITS-1:0] col_adr(input logic [CFW-1:0] col);
    logic [DDR_ROW_BITS-1:0] a;
    a = {DDR_ROW_BITS{1'b0}};
    a[DDR_COL_BITS-1:3] = col;
    return a;
  endfunction

  assign w_wr_row    = mem_wradr_i[ADDRS-1 -: DDR_ROW_BITS];
  assign w_wr_ba     = mem_wradr_i[CFW +: DDR_BANK_BITS];
  assign w_wr_col    = mem_wradr_i[CFW-1:0];
  assign w_rd_row    = mem_rdadr_i[ADDRS-1 -: DDR_ROW_BITS];
  assign w_rd_ba     = mem_rdadr_i[CFW +: DDR_BANK_BITS];
  assign w_rd_col    = mem_rdadr_i[CFW-1:0];
  assign w_wr_hit    = r_open[w_wr_ba] && (r_row[w_wr_ba] == w_wr_row);
  assign w_rd_hit    = r_open[w_rd_ba] && (r_row[w_rd_ba] == w_rd_row);
  assign w_any_req   = mem_wrreq_i || mem_rdreq_i;
  assign w_xfer      = r_req && ddl_rdy_i;
  assign w_ack_cycle = r_wrack || r_rdack;

  // Port arbitration: lone requester, then the single row hit, then round-robin.
  always_comb begin
    w_sel_wr = 1'b0;
    if (mem_wrreq_i && !mem_rdreq_i) begin
      w_sel_wr = 1'b1;
    end else if (!mem_wrreq_i && mem_rdreq_i) begin
      w_sel_wr = 1'b0;
    end else if (w_wr_hit != w_rd_hit) begin
      w_sel_wr = w_wr_hit;
    end else begin
      w_sel_wr = !r_prefer_rd;
    end
  end

  // Fields of the selected request.
  always_comb begin
    w_sel_row  = w_rd_row;
    w_sel_ba   = w_rd_ba;
    w_sel_col  = w_rd_col;
    w_sel_tid  = mem_rdtid_i;
    w_sel_hit  = w_rd_hit;
    w_sel_open = r_open[w_rd_ba];
    if (w_sel_wr) begin
      w_sel_row  = w_wr_row;
      w_sel_ba   = w_wr_ba;
      w_sel_col  = w_wr_col;
      w_sel_tid  = mem_wrtid_i;
      w_sel_hit  = w_wr_hit;
      w_sel_open = r_open[w_wr_ba];
    end else begin
      w_sel_open = r_open[w_rd_ba];
    end
  end

  // Bank table follows accepted ACT, PRE and PREA commands.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_open <= {BANKS{1'b0}};
      for (int i = 0; i < BANKS; i++) r_row[i] <= {DDR_ROW_BITS{1'b0}};
    end else if (w_xfer) begin
      case (r_state)
        S_ACTV: begin
          r_open[r_ba] <= 1'b1;
          r_row[r_ba]  <= r_req_row;
        end
        S_PREC:  r_open[r_ba] <= 1'b0;
        S_PREA:  r_open <= {BANKS{1'b0}};
        default: ;
      endcase
    end
  end

  // Command sequencer; every command field is registered and only advances on accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_cmd       <= CMD_NOOP;
      r_tid       <= {REQID{1'b0}};
      r_ba        <= {DDR_BANK_BITS{1'b0}};
      r_adr       <= {DDR_ROW_BITS{1'b0}};
      r_wrack     <= 1'b0;
      r_rdack     <= 1'b0;
      r_prefer_rd <= 1'b1;
      r_req_wr    <= 1'b0;
      r_req_row   <= {DDR_ROW_BITS{1'b0}};
      r_req_col   <= {CFW{1'b0}};
      r_req_tid   <= {REQID{1'b0}};
    end else begin
      r_wrack <= 1'b0;
      r_rdack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The acked requester still holds its request this cycle, so stay put.
          if (!w_ack_cycle && ddl_ref_i) begin
            r_req <= 1'b1;
            r_tid <= {REQID{1'b0}};
            r_ba  <= {DDR_BANK_BITS{1'b0}};
            if (|r_open) begin
              r_state <= S_PREA;
              r_cmd   <= CMD_PREC;
              r_adr   <= ADR_A10;
            end else begin
              r_state <= S_REFR;
              r_cmd   <= CMD_REFR;
              r_adr   <= {DDR_ROW_BITS{1'b0}};
            end
          end else if (!w_ack_cycle && w_any_req) begin
            r_req_wr    <= w_sel_wr;
            r_req_row   <= w_sel_row;
            r_req_col   <= w_sel_col;
            r_req_tid   <= w_sel_tid;
            r_prefer_rd <= w_sel_wr;
            r_req       <= 1'b1;
            r_ba        <= w_sel_ba;
            if (w_sel_hit) begin
              r_state <= S_RDWR;
              r_cmd   <= w_sel_wr ? CMD_WRIT : CMD_READ;
              r_adr   <= col_adr(w_sel_col);
              r_tid   <= w_sel_tid;
            end else if (w_sel_open) begin
              r_state <= S_PREC;
              r_cmd   <= CMD_PREC;
              r_adr   <= {DDR_ROW_BITS{1'b0}};
              r_tid   <= {REQID{1'b0}};
            end else begin
              r_state <= S_ACTV;
              r_cmd   <= CMD_ACTV;
              r_adr   <= w_sel_row;
              r_tid   <= {REQID{1'b0}};
            end
          end
        end
        S_PREC: if (w_xfer) begin
          r_state <= S_ACTV;
          r_cmd   <= CMD_ACTV;
          r_adr   <= r_req_row;
        end
        S_ACTV: if (w_xfer) begin
          r_state <= S_RDWR;
          r_cmd   <= r_req_wr ? CMD_WRIT : CMD_READ;
          r_adr   <= col_adr(r_req_col);
          r_tid   <= r_req_tid;
        end
        S_RDWR: if (w_xfer) begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_cmd   <= CMD_NOOP;
          r_tid   <= {REQID{1'b0}};
          r_ba    <= {DDR_BANK_BITS{1'b0}};
          r_adr   <= {DDR_ROW_BITS{1'b0}};
          r_wrack <= r_req_wr;
          r_rdack <= !r_req_wr;
        end
        S_PREA: if (w_xfer) begin
          r_state <= S_REFR;
          r_cmd   <= CMD_REFR;
          r_adr   <= {DDR_ROW_BITS{1'b0}};
        end
        S_REFR: if (w_xfer) begin
          r_state <= S_REFW;
          r_req   <= 1'b0;
          r_cmd   <= CMD_NOOP;
        end
        S_REFW: if (!ddl_ref_i) begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_cmd   <= CMD_NOOP;
        end
      endcase
    end
  end

  assign ddl_req_o   = r_req;
  assign ddl_cmd_o   = r_cmd;
  assign ddl_tid_o   = r_tid;
  assign ddl_ba_o    = r_ba;
  assign ddl_adr_o   = r_adr;
  assign mem_wrack_o = r_wrack;
  assign mem_rdack_o = r_rdack;

endmodule

// File: tb/tb_ddr3_bank_sched.sv
// Randomized scoreboard bench for ddr3_bank_sched against a transaction-level bank/arbiter model.
module tb_ddr3_bank_sched;
  localparam int REQID = 4, RB = 13, BB = 3, CB = 10, CF = CB - 3;
  localparam int AW = RB + BB + CB - 3;
  localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_NOP = 3'b111;
  localparam logic [RB-1:0] A10 = 13'h0400, FULL = 13'h1fff;

  logic clock = 1'b0, reset = 1'b1;
  logic mem_wrreq_i = 1'b0, mem_rdreq_i = 1'b0, ddl_rdy_i = 1'b1, ddl_ref_i = 1'b0;
  logic [REQID-1:0] mem_wrtid_i = '0, mem_rdtid_i = '0;
  logic [AW-1:0] mem_wradr_i = '0, mem_rdadr_i = '0;
  logic mem_wrack_o, mem_rdack_o, ddl_req_o;
  logic [2:0] ddl_cmd_o;
  logic [REQID-1:0] ddl_tid_o;
  logic [BB-1:0] ddl_ba_o;
  logic [RB-1:0] ddl_adr_o;

  ddr3_bank_sched dut (
    .clock(clock), .reset(reset),
    .mem_wrreq_i(mem_wrreq_i), .mem_wrtid_i(mem_wrtid_i), .mem_wradr_i(mem_wradr_i), .mem_wrack_o(mem_wrack_o),
    .mem_rdreq_i(mem_rdreq_i), .mem_rdtid_i(mem_rdtid_i), .mem_rdadr_i(mem_rdadr_i), .mem_rdack_o(mem_rdack_o),
    .ddl_req_o(ddl_req_o), .ddl_rdy_i(ddl_rdy_i), .ddl_ref_i(ddl_ref_i), .ddl_cmd_o(ddl_cmd_o),
    .ddl_tid_o(ddl_tid_o), .ddl_ba_o(ddl_ba_o), .ddl_adr_o(ddl_adr_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] cmd;
    logic [BB-1:0] ba;
    bit chk_ba;
    logic [RB-1:0] adr;
    logic [RB-1:0] mask;
    logic [REQID-1:0] tid;
  } cmd_t;

  cmd_t cmd_q[$];
  bit   ack_q[$];
  int   total = 0, bad = 0;
  bit   rnd_rdy = 1'b0, hold_low = 1'b0, refr_seen = 1'b0, ref_wait = 1'b0;

  // Reference model: which banks are open, with which row, and who is preferred next.
  bit m_open [8];
  logic [RB-1:0] m_row [8];
  bit m_pref_rd = 1'b1;

  function automatic logic [AW-1:0] mk(int row, int ba, int col);
    return {RB'(row), BB'(ba), CF'(col)};
  endfunction

  function automatic void push_cmd(logic [2:0] c, logic [BB-1:0] b, bit cb, logic [RB-1:0] ad,
                                   logic [RB-1:0] msk, logic [REQID-1:0] t);
    cmd_t e;
    e.cmd = c; e.ba = b; e.chk_ba = cb; e.adr = ad; e.mask = msk; e.tid = t;
    cmd_q.push_back(e);
  endfunction

  function automatic bit m_hit(logic [AW-1:0] a);
    logic [BB-1:0] b = a[CF +: BB];
    return m_open[b] && (m_row[b] == a[AW-1 -: RB]);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
    m_pref_rd = 1'b1;
  endfunction

  function automatic void m_refresh();
    bit any = 1'b0;
    for (int i = 0; i < 8; i++) any |= m_open[i];
    if (any) push_cmd(C_PRE, 3'd0, 1'b0, A10, A10, 4'd0);
    push_cmd(C_REF, 3'd0, 1'b0, 13'd0, 13'd0, 4'd0);
    for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
  endfunction

  // Returns the number of DFI commands the transaction needs.
  function automatic int m_serve(bit wr, logic [AW-1:0] a, logic [REQID-1:0] t);
    logic [RB-1:0] row = a[AW-1 -: RB];
    logic [BB-1:0] b = a[CF +: BB];
    logic [RB-1:0] cad = RB'(a[CF-1:0]) * 13'd8;
    int n = 1;
    if (!m_hit(a)) begin
      if (m_open[b]) begin
        push_cmd(C_PRE, b, 1'b1, 13'd0, A10, 4'd0);
        n++;
      end
      push_cmd(C_ACT, b, 1'b1, row, FULL, 4'd0);
      n++;
      m_open[b] = 1'b1;
      m_row[b] = row;
    end
    push_cmd(wr ? C_WR : C_RD, b, 1'b1, cad, FULL, t);
    ack_q.push_back(wr);
    m_pref_rd = wr;
    return n;
  endfunction

  always @(posedge clock) begin
    #1;
    if (hold_low) ddl_rdy_i = 1'b0;
    else if (rnd_rdy) ddl_rdy_i = ($urandom_range(0, 3) != 0);
    else ddl_rdy_i = 1'b1;
  end

  logic p_stall = 1'b0;
  logic [2:0] p_cmd;
  logic [BB-1:0] p_ba;
  logic [RB-1:0] p_adr;
  logic [REQID-1:0] p_tid;

  // Monitor: scoreboard pops, stall stability and refresh-wait quiet checks.
  always @(negedge clock) begin
    cmd_t e;
    if (reset) begin
      p_stall = 1'b0;
      ref_wait = 1'b0;
    end else begin
      if (p_stall) begin
        total++;
        if (!ddl_req_o || ddl_cmd_o !== p_cmd || ddl_ba_o !== p_ba || ddl_adr_o !== p_adr ||
            ddl_tid_o !== p_tid || mem_wrack_o || mem_rdack_o) begin
          bad++;
          $display("FAIL stall_hold: got req=%b cmd=%b ba=%0d adr=%h tid=%0d ack=%b%b, need cmd=%b ba=%0d adr=%h tid=%0d no ack",
                   ddl_req_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o, ddl_tid_o, mem_wrack_o, mem_rdack_o,
                   p_cmd, p_ba, p_adr, p_tid);
        end
      end
      if (ref_wait && ddl_ref_i) begin
        total++;
        if (ddl_req_o !== 1'b0) begin
          bad++;
          $display("FAIL ref_quiet: got ddl_req_o=%b, need 0", ddl_req_o);
        end
      end
      if (!ddl_ref_i) ref_wait = 1'b0;
      if (ddl_req_o && ddl_rdy_i) begin
        total++;
        if (cmd_q.size() == 0) begin
          bad++;
          $display("FAIL cmd_extra: got cmd=%b ba=%0d adr=%h, need none", ddl_cmd_o, ddl_ba_o, ddl_adr_o);
        end else begin
          e = cmd_q.pop_front();
          if (ddl_cmd_o !== e.cmd || (e.chk_ba && ddl_ba_o !== e.ba) ||
              ((ddl_adr_o & e.mask) !== (e.adr & e.mask)) || ddl_tid_o !== e.tid) begin
            bad++;
            $display("FAIL cmd: got cmd=%b ba=%0d adr=%h tid=%0d, need cmd=%b ba=%0d adr=%h mask=%h tid=%0d",
                     ddl_cmd_o, ddl_ba_o, ddl_adr_o, ddl_tid_o, e.cmd, e.ba, e.adr, e.mask, e.tid);
          end
        end
        if (ddl_cmd_o == C_REF) begin
          ref_wait = 1'b1;
          refr_seen = 1'b1;
        end
      end
      if (mem_wrack_o || mem_rdack_o) begin
        total++;
        if (ack_q.size() == 0 || (mem_wrack_o && mem_rdack_o)) begin
          bad++;
          $display("FAIL ack_extra: got wrack=%b rdack=%b, need none", mem_wrack_o, mem_rdack_o);
        end else if (ack_q.pop_front() != mem_wrack_o) begin
          bad++;
          $display("FAIL ack_dir: got wrack=%b rdack=%b, need the other port", mem_wrack_o, mem_rdack_o);
        end
      end
      p_stall = ddl_req_o && !ddl_rdy_i;
      p_cmd = ddl_cmd_o; p_ba = ddl_ba_o; p_adr = ddl_adr_o; p_tid = ddl_tid_o;
    end
  end

  task automatic chk_idle_outputs(string name);
    total++;
    if (ddl_req_o !== 1'b0 || ddl_cmd_o !== C_NOP || ddl_ba_o !== 3'd0 || ddl_adr_o !== 13'd0 ||
        ddl_tid_o !== 4'd0 || mem_wrack_o !== 1'b0 || mem_rdack_o !== 1'b0) begin
      bad++;
      $display("FAIL %s: got req=%b cmd=%b ba=%0d adr=%h tid=%0d ack=%b%b, need 0 NOOP 0 0 0 00",
               name, ddl_req_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o, ddl_tid_o, mem_wrack_o, mem_rdack_o);
    end
  endtask

  // Present requests (and optionally refresh) together, then hold each until served.
  task automatic batch(bit dw, bit dr, bit dref, logic [AW-1:0] wa, logic [REQID-1:0] wt,
                       logic [AW-1:0] ra, logic [REQID-1:0] rt, bit chk_lat);
    int n = 0, cyc = 0, lat = 0, refcnt = 0, dummy;
    bit wdone, rdone, refdone, dropw, dropr, first_wr;
    if (dref) m_refresh();
    if (dw && dr) begin
      first_wr = (m_hit(wa) != m_hit(ra)) ? m_hit(wa) : !m_pref_rd;
      if (first_wr) begin
        dummy = m_serve(1'b1, wa, wt);
        dummy = m_serve(1'b0, ra, rt);
      end else begin
        dummy = m_serve(1'b0, ra, rt);
        dummy = m_serve(1'b1, wa, wt);
      end
    end else if (dw) n = m_serve(1'b1, wa, wt);
    else if (dr) n = m_serve(1'b0, ra, rt);
    @(posedge clock); #1;
    refr_seen = 1'b0;
    mem_wrreq_i = dw; mem_wradr_i = wa; mem_wrtid_i = wt;
    mem_rdreq_i = dr; mem_rdadr_i = ra; mem_rdtid_i = rt;
    ddl_ref_i = dref;
    wdone = !dw; rdone = !dr; refdone = !dref;
    while (!(wdone && rdone && refdone) && cyc < 300) begin
      @(negedge clock);
      cyc++;
      dropw = !wdone && mem_wrack_o;
      dropr = !rdone && mem_rdack_o;
      if ((dropw || dropr) && lat == 0) lat = cyc;
      if (!refdone && refr_seen) refcnt++;
      @(posedge clock); #1;
      if (dropw) begin mem_wrreq_i = 1'b0; wdone = 1'b1; end
      if (dropr) begin mem_rdreq_i = 1'b0; rdone = 1'b1; end
      if (!refdone && refcnt >= 3) begin ddl_ref_i = 1'b0; refdone = 1'b1; end
    end
    if (!(wdone && rdone && refdone)) begin
      total++; bad++;
      $display("FAIL batch_timeout: got wdone=%b rdone=%b refdone=%b, need all 1", wdone, rdone, refdone);
    end else if (chk_lat) begin
      total++;
      if (lat != 2 + n) begin
        bad++;
        $display("FAIL ack_latency: got %0d, need %0d", lat, 2 + n);
      end
    end
    mem_wrreq_i = 1'b0; mem_rdreq_i = 1'b0; ddl_ref_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, need finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_idle_outputs("reset_state");
    @(posedge clock); #1;
    reset = 1'b0;

    batch(1'b0, 1'b1, 1'b0, '0, 4'd0, mk(5, 2, 8), 4'd3, 1'b1);      // closed bank
    batch(1'b1, 1'b0, 1'b0, mk(5, 2, 16), 4'd7, '0, 4'd0, 1'b1);     // row hit
    batch(1'b0, 1'b1, 1'b0, '0, 4'd0, mk(9, 2, 0), 4'd1, 1'b1);      // row conflict
    batch(1'b1, 1'b1, 1'b0, mk(9, 2, 5), 4'd2, mk(1, 2, 6), 4'd4, 1'b0);
    batch(1'b1, 1'b1, 1'b0, mk(2, 5, 1), 4'd5, mk(3, 4, 2), 4'd6, 1'b0);
    batch(1'b0, 1'b1, 1'b1, '0, 4'd0, mk(9, 2, 3), 4'd8, 1'b0);      // refresh with bank open

    hold_low = 1'b1;
    fork
      batch(1'b0, 1'b1, 1'b0, '0, 4'd0, mk(1, 6, 9), 4'd9, 1'b0);
      begin
        for (int i = 0; i < 20 && !ddl_req_o; i++) @(negedge clock);
        total++;
        if (!ddl_req_o || ddl_cmd_o !== C_ACT) begin
          bad++;
          $display("FAIL bp_act: got req=%b cmd=%b, need 1 %b", ddl_req_o, ddl_cmd_o, C_ACT);
        end
        repeat (5) @(posedge clock);
        hold_low = 1'b0;
      end
    join

    rnd_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      bit dw, dr, dref;
      dref = ($urandom_range(0, 7) == 0);
      dw = $urandom_range(0, 1) != 0;
      dr = $urandom_range(0, 1) != 0;
      if (!dw && !dr && !dref) dr = 1'b1;
      batch(dw, dr, dref,
            mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 127)), 4'($urandom_range(0, 15)),
            mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 127)), 4'($urandom_range(0, 15)),
            1'b0);
    end
    rnd_rdy = 1'b0;

    batch(1'b0, 1'b1, 1'b0, '0, 4'd0, mk(7, 2, 4), 4'd2, 1'b0);
    hold_low = 1'b1;
    @(posedge clock); #1;
    mem_rdreq_i = 1'b1; mem_rdadr_i = mk(3, 2, 1); mem_rdtid_i = 4'd11;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    mem_rdreq_i = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk_idle_outputs("midseq_reset");
    @(posedge clock); #1;
    reset = 1'b0;
    hold_low = 1'b0;
    cmd_q.delete();
    ack_q.delete();
    m_reset();
    @(negedge clock);
    chk_idle_outputs("after_reset");
    batch(1'b0, 1'b1, 1'b0, '0, 4'd0, mk(3, 2, 1), 4'd11, 1'b1);     // table must be clear

    repeat (3) @(posedge clock);
    total++;
    if (cmd_q.size() != 0 || ack_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got cmds=%0d acks=%0d, need 0 0", cmd_q.size(), ack_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
